// File: rtl/binary_attn_pkg.sv
// Shared defaults, width helper and run-FSM state type for the binary attention-score engine.
package binary_attn_pkg;

    localparam int unsigned SEQ_LEN_DEF  = 30;
    localparam int unsigned N_HEADS_DEF  = 4;
    localparam int unsigned HEAD_DIM_DEF = 4;

    // Bits needed to hold values 0..n-1; never returns less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bin_popcmp.sv
// One head/key cell: Hamming distance of key vs query, thresholded to a 1-bit score.
module bin_popcmp
    import binary_attn_pkg::*;
#(
    parameter int unsigned HEAD_DIM = HEAD_DIM_DEF
) (
    input  logic [HEAD_DIM-1:0]              key,
    input  logic [HEAD_DIM-1:0]              query,
    input  logic [width_of(HEAD_DIM+1):0]    thr,
    output logic                             score
);

    localparam int unsigned CNT_W = width_of(HEAD_DIM + 1);

    logic [HEAD_DIM-1:0] diff;
    logic [CNT_W-1:0]    pop;

    assign diff = key ^ query;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < HEAD_DIM; i++) begin
            pop = pop + CNT_W'(diff[i]);
        end
    end

    // 2*pop and thr both widened by one bit so the compare cannot wrap.
    assign score = {1'b0, pop, 1'b0} > {1'b0, thr};

endmodule

// File: rtl/binary_attn_score.sv
// Binary attention-score engine: run FSM, query counter, threshold latch and registered score output.
module binary_attn_score
    import binary_attn_pkg::*;
#(
    parameter int unsigned SEQ_LEN  = SEQ_LEN_DEF,
    parameter int unsigned N_HEADS  = N_HEADS_DEF,
    parameter int unsigned HEAD_DIM = HEAD_DIM_DEF,
    parameter int unsigned CNT_W    = width_of(HEAD_DIM + 1),
    parameter int unsigned THR_W    = CNT_W + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [THR_W-1:0]                    threshold,
    input  logic [SEQ_LEN*N_HEADS*HEAD_DIM-1:0] key_in,
    input  logic                                q_valid,
    output logic                                q_ready,
    input  logic [N_HEADS*HEAD_DIM-1:0]         query_in,
    output logic                                s_valid,
    input  logic                                s_ready,
    output logic [N_HEADS*SEQ_LEN-1:0]          score_out,
    output logic                                s_last,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned     QCW    = width_of(SEQ_LEN + 1);
    localparam logic [QCW-1:0]  Q_MAX  = QCW'(SEQ_LEN);
    localparam logic [QCW-1:0]  Q_LAST = QCW'(SEQ_LEN - 1);

    state_t                     state, state_nxt;
    logic [QCW-1:0]             q_cnt;
    logic [THR_W-1:0]           thr_q;
    logic [N_HEADS*SEQ_LEN-1:0] score_w;
    logic                       q_hs, s_hs, last_hs;

    assign q_hs    = q_valid & q_ready;
    assign s_hs    = s_valid & s_ready;
    assign last_hs = (state == RUN) & s_hs & s_last;

    for (genvar h = 0; h < N_HEADS; h++) begin : g_head
        for (genvar k = 0; k < SEQ_LEN; k++) begin : g_key
            bin_popcmp #(
                .HEAD_DIM(HEAD_DIM)
            ) u_cell (
                .key  (key_in[(k*N_HEADS+h)*HEAD_DIM +: HEAD_DIM]),
                .query(query_in[h*HEAD_DIM +: HEAD_DIM]),
                .thr  (thr_q),
                .score(score_w[h*SEQ_LEN+k])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = RUN;
            RUN:     if (last_hs) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        q_ready = (state == RUN) && (q_cnt < Q_MAX) && (!s_valid || s_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt <= '0;
            thr_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_hs;
            if (state == IDLE && start) begin
                q_cnt <= '0;
                thr_q <= threshold;
            end else if (q_hs) begin
                q_cnt <= q_cnt + 1'b1;
            end
        end
    end

    // A new accept takes priority over draining, so the word reloads with s_valid held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid   <= 1'b0;
            score_out <= '0;
            s_last    <= 1'b0;
        end else if (q_hs) begin
            s_valid   <= 1'b1;
            score_out <= score_w;
            s_last    <= (q_cnt == Q_LAST);
        end else if (s_hs) begin
            s_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binary_attn_score.sv
// Scoreboard bench for binary_attn_score: expected score words queued at query accept, compared at output handshake.
module tb_binary_attn_score;

    localparam int SEQ   = 30;
    localparam int NH    = 4;
    localparam int HD    = 4;
    localparam int THR_W = 4;
    localparam int KW    = SEQ*NH*HD;
    localparam int QW    = NH*HD;
    localparam int SW    = NH*SEQ;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [THR_W-1:0]  threshold = '0;
    logic [KW-1:0]     key_in = '0;
    logic              q_valid = 1'b0;
    logic              q_ready;
    logic [QW-1:0]     query_in = '0;
    logic              s_valid;
    logic              s_ready = 1'b0;
    logic [SW-1:0]     score_out;
    logic              s_last;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    logic [SW:0]   exp_q[$];
    logic [SW-1:0] first_word;
    int            qmode;

    binary_attn_score #(
        .SEQ_LEN (SEQ),
        .N_HEADS (NH),
        .HEAD_DIM(HD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .threshold(threshold),
        .key_in   (key_in),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .query_in (query_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .score_out(score_out),
        .s_last   (s_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] model(input logic [QW-1:0] q, input int thr);
        logic [SW-1:0] r;
        logic [HD-1:0] kk, qq;
        int pop;
        r = '0;
        for (int h = 0; h < NH; h++) begin
            for (int k = 0; k < SEQ; k++) begin
                kk = key_in[(k*NH+h)*HD +: HD];
                qq = q[h*HD +: HD];
                pop = $countones(kk ^ qq);
                r[h*SEQ+k] = (2*pop > thr);
            end
        end
        return r;
    endfunction

    function automatic logic [QW-1:0] gen_query();
        return (qmode == 0) ? '0 : QW'($urandom());
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q_ready"}, q_ready, 0);
        chk({tag, "_s_valid"}, s_valid, 0);
        chk({tag, "_score"}, score_out, 0);
        chk({tag, "_s_last"}, s_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // pat: 0 = s_ready tied high, 1 = repeating 1,0,0,1
    task automatic run_once(input logic [THR_W-1:0] thr, input int pat, input int abort_at, input bit poke_start);
        int acc, outs, cyc, dones;
        bit hold_chk, acc_now;
        logic [SW-1:0] held_s;
        logic held_l;
        logic [SW:0] e;
        exp_q.delete();
        acc = 0; outs = 0; cyc = 0; dones = 0; hold_chk = 0; held_s = '0; held_l = 0;
        @(negedge clk);
        start = 1'b1; threshold = thr; q_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; threshold = ~thr; q_valid = 1'b1; query_in = gen_query();
        #1 chk("busy_rise", busy, 1);
        while (outs < SEQ && cyc < 3000) begin
            if (abort_at >= 0 && acc >= abort_at) break;
            s_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start   = poke_start && (cyc == 5);
            #1;
            if (hold_chk) begin
                chk("hold_score", score_out, held_s);
                chk("hold_last", s_last, held_l);
            end
            if (done) dones++;
            if (acc == SEQ) chk("q_ready_sat", q_ready, 0);
            if (s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("score", score_out, e[SW-1:0]);
                    chk("s_last", s_last, e[SW]);
                end
                if (outs == 0) first_word = score_out;
                outs++;
            end
            hold_chk = s_valid && !s_ready;
            held_s   = score_out;
            held_l   = s_last;
            acc_now  = q_valid && q_ready;
            if (acc_now) begin
                exp_q.push_back({(acc == SEQ-1), model(query_in, int'(thr))});
                acc++;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (acc_now) query_in = gen_query();
            cyc++;
        end
        if (cyc >= 3000) chk("timeout", outs, SEQ);
        if (abort_at >= 0) begin
            #1 rst_n = 1'b0;
            #1 check_reset_outputs("abort");
            q_valid = 1'b0; s_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            dones = 0;
            repeat (4) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("abort_no_done", dones, 0);
            chk("abort_idle", busy, 0);
            return;
        end
        q_valid = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("s_valid_end", s_valid, 0);
        chk("early_done", dones, 0);
        chk("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        #1 chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        qmode = 0; key_in = '0;
        run_once(4'd4, 0, -1, 0);
        chk("zero_first", first_word, 0);

        key_in = '0;
        key_in[3:0]   = 4'b1111;
        key_in[19:16] = 4'b0011;
        key_in[35:32] = 4'b0111;
        run_once(4'd4, 0, -1, 0);
        chk("pop4_thr4", first_word[0], 1);
        chk("pop2_thr4", first_word[1], 0);
        chk("pop3_thr4", first_word[2], 1);

        key_in = '1;
        run_once(4'd8, 0, -1, 0);
        chk("thr8_zero", first_word, 0);

        key_in = {(KW/HD){4'b0001}};
        run_once(4'd0, 0, -1, 0);
        chk("thr0_pop1", first_word, {SW{1'b1}});

        qmode = 1;
        for (int i = 0; i < KW; i++) key_in[i] = 1'($urandom_range(1, 0));
        run_once(4'd3, 1, -1, 1);
        run_once(4'd5, 0, -1, 0);

        run_once(4'd4, 1, 12, 0);
        run_once(4'd4, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

endmodule
